// File: rtl/ppu_cpu_bridge.sv
// CPU-side initiator for the PPU register window: stretches single CPU requests
// into slow ppu_ncs-framed accesses and runs the $4014 sprite DMA into $2004.
module ppu_cpu_bridge #(
  parameter int NCS_LOW_CYCLES  = 4,
  parameter int NCS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        dma_busy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        ppu_ncs,
  output logic [2:0]  ppu_sel,
  output logic        ppu_r_nw,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata
);

  typedef enum logic [2:0] {IDLE, ACCESS, RECOVER, DMA_RD, DMA_WAIT} state_t;

  localparam logic [3:0] LOW_LAST  = 4'(NCS_LOW_CYCLES - 1);
  localparam logic [3:0] HIGH_LAST = 4'(NCS_HIGH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        dma_q, dma_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;

  logic is_ppu;
  logic is_dma;

  // $2000-$3FFF is the mirrored PPU window; only a write to $4014 starts DMA
  assign is_ppu = (cpu_addr[15:13] == 3'b001);
  assign is_dma = (cpu_addr == 16'h4014) && !cpu_rnw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rnw_d   = rnw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    dma_d   = dma_q;
    page_d  = page_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (is_ppu) begin
            sel_d   = cpu_addr[2:0];
            rnw_d   = cpu_rnw;
            wdata_d = cpu_wdata;
            cnt_d   = 4'd0;
            state_d = ACCESS;
          end else if (is_dma) begin
            page_d  = cpu_wdata;
            idx_d   = 8'd0;
            dma_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = DMA_RD;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == LOW_LAST) begin
          if (!dma_q && rnw_q) rdata_d = ppu_rdata;
          ack_d   = !dma_q;
          rnw_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == HIGH_LAST) begin
          cnt_d = 4'd0;
          if (dma_q) begin
            idx_d = idx_q + 8'd1;
            if (idx_q == 8'hFF) begin
              dma_d   = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = DMA_RD;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DMA_RD: state_d = DMA_WAIT;
      DMA_WAIT: begin
        // Memory data arrives this cycle; turn it into a $2004 write
        wdata_d = mem_rdata;
        sel_d   = 3'd4;
        rnw_d   = 1'b0;
        cnt_d   = 4'd0;
        state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 3'd0;
      rnw_q   <= 1'b1;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      ack_q   <= 1'b0;
      dma_q   <= 1'b0;
      page_q  <= 8'd0;
      idx_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rnw_q   <= rnw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      dma_q   <= dma_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
    end
  end

  // Strobes decode straight from state so they cannot leak outside their states
  assign ppu_ncs   = (state_q != ACCESS);
  assign mem_rd    = (state_q == DMA_RD);
  assign mem_addr  = {page_q, idx_q};
  assign ppu_sel   = sel_q;
  assign ppu_r_nw  = rnw_q;
  assign ppu_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign dma_busy  = dma_q;

endmodule

// File: tb/tb_ppu_cpu_bridge.sv
// Directed bench for ppu_cpu_bridge: access framing, read return, spacing,
// address filtering, sprite DMA and mid-operation reset.
module tb_ppu_cpu_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_rnw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        dma_busy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        ppu_ncs;
  logic [2:0]  ppu_sel;
  logic        ppu_r_nw;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [39:0] RESET_VEC = {1'b1, 3'd0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000};

  ppu_cpu_bridge #(.NCS_LOW_CYCLES(4), .NCS_HIGH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .dma_busy(dma_busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .ppu_ncs(ppu_ncs), .ppu_sel(ppu_sel), .ppu_r_nw(ppu_r_nw),
    .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata)
  );

  always #5 clk = ~clk;

  // CPU memory: byte k of any page reads as k ^ 0x5A, one cycle after mem_rd
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

  function automatic logic [39:0] out_vec();
    return {ppu_ncs, ppu_sel, ppu_r_nw, ppu_wdata, cpu_rdata, cpu_ack, dma_busy, mem_rd, mem_addr};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL reset_values got %h want %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 16'h2000; cpu_wdata = 8'h80;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (c <= 4) begin
        if ({ppu_ncs, ppu_sel, ppu_r_nw, ppu_wdata} !== {1'b0, 3'd0, 1'b0, 8'h80}) begin
          errors++;
          $display("[TB] FAIL write_low c%0d got %b/%0d/%b/%h want 0/0/0/80", c, ppu_ncs, ppu_sel, ppu_r_nw, ppu_wdata);
        end
      end else if (ppu_ncs !== 1'b1) begin
        errors++;
        $display("[TB] FAIL write_high c%0d ncs got %b want 1", c, ppu_ncs);
      end
      checks++;
      if (cpu_ack !== (c == 5)) begin
        errors++;
        $display("[TB] FAIL write_ack c%0d got %b want %b", c, cpu_ack, (c == 5));
      end
      if (c == 5) cpu_req = 1'b0;
    end
  endtask

  task automatic test_read();
    ppu_rdata = 8'hA5;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'h3FFA; cpu_wdata = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 4) begin
        checks++;
        if ({ppu_ncs, ppu_sel, ppu_r_nw} !== {1'b0, 3'd2, 1'b1}) begin
          errors++;
          $display("[TB] FAIL read_low c%0d got %b/%0d/%b want 0/2/1", c, ppu_ncs, ppu_sel, ppu_r_nw);
        end
      end
      if (c == 5) begin
        checks++;
        if ({cpu_ack, cpu_rdata, ppu_ncs} !== {1'b1, 8'hA5, 1'b1}) begin
          errors++;
          $display("[TB] FAIL read_ack got ack=%b rdata=%h ncs=%b want 1/a5/1", cpu_ack, cpu_rdata, ppu_ncs);
        end
        cpu_req = 1'b0;
      end else begin
        checks++;
        if (cpu_ack !== 1'b0) begin
          errors++;
          $display("[TB] FAIL read_spurious_ack c%0d got %b want 0", c, cpu_ack);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int falls[$];
    int acks = 0;
    int low_cycles = 0;
    logic prev_ncs = 1'b1;
    ppu_rdata = 8'h00;
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 16'h2006; cpu_wdata = 8'h21;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (prev_ncs && !ppu_ncs) falls.push_back(c);
      prev_ncs = ppu_ncs;
      if (!ppu_ncs) low_cycles++;
      if (c == 8) begin
        checks++;
        if (ppu_wdata !== 8'h08) begin
          errors++;
          $display("[TB] FAIL b2b_second_data got %h want 08", ppu_wdata);
        end
      end
      if (cpu_ack) begin
        acks++;
        if (acks == 1) cpu_wdata = 8'h08;
        else cpu_req = 1'b0;
      end
    end
    checks++;
    if (falls.size() != 2 || falls[0] != 1 || falls[1] != 8) begin
      errors++;
      $display("[TB] FAIL b2b_falls got count=%0d first=%0d second=%0d want 2/1/8",
               falls.size(), (falls.size() > 0) ? falls[0] : -1, (falls.size() > 1) ? falls[1] : -1);
    end
    checks++;
    if (low_cycles != 8 || acks != 2) begin
      errors++;
      $display("[TB] FAIL b2b_overlap got low=%0d acks=%0d want 8/2", low_cycles, acks);
    end
    checks++;
    if (cpu_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL write_keeps_rdata got %h want a5", cpu_rdata);
    end
  endtask

  task automatic test_ignored();
    logic [16:0] reqs [2];
    reqs[0] = {1'b0, 16'h4000};
    reqs[1] = {1'b1, 16'h4014};
    for (int r = 0; r < 2; r++) begin
      cpu_req = 1'b1; cpu_rnw = reqs[r][16]; cpu_addr = reqs[r][15:0]; cpu_wdata = 8'h33;
      for (int c = 1; c <= 20; c++) begin
        tick();
        checks++;
        if ({ppu_ncs, cpu_ack, dma_busy} !== 3'b100) begin
          errors++;
          $display("[TB] FAIL ignored_%h c%0d ncs/ack/busy got %b want 100", cpu_addr, c, {ppu_ncs, cpu_ack, dma_busy});
        end
      end
      cpu_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_dma();
    int busy_cycles = 0;
    int strobes = 0;
    int writes = 0;
    int ack_cycle = -1;
    int bad_ack = 0;
    logic prev_ncs = 1'b1;
    logic [7:0] exp_b;
    ppu_rdata = 8'h3C;
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h02;
    for (int c = 1; c <= 3000 && ack_cycle < 0; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if ({cpu_ack, dma_busy} !== 2'b11) begin
          errors++;
          $display("[TB] FAIL dma_start ack/busy got %b want 11", {cpu_ack, dma_busy});
        end
        cpu_rnw = 1'b1; cpu_addr = 16'h2002; cpu_wdata = 8'h00;
      end else if (cpu_ack) begin
        if (dma_busy) bad_ack++;
        else ack_cycle = c;
      end
      if (dma_busy) busy_cycles++;
      if (mem_rd) begin
        exp_b = 8'(strobes);
        checks++;
        if (mem_addr !== {8'h02, exp_b}) begin
          errors++;
          $display("[TB] FAIL dma_mem_addr got %h want %h", mem_addr, {8'h02, exp_b});
        end
        strobes++;
      end
      if (prev_ncs && !ppu_ncs && dma_busy) begin
        exp_b = 8'(writes) ^ 8'h5A;
        checks++;
        if ({ppu_sel, ppu_r_nw, ppu_wdata} !== {3'd4, 1'b0, exp_b}) begin
          errors++;
          $display("[TB] FAIL dma_write%0d got sel=%0d rnw=%b data=%h want 4/0/%h", writes, ppu_sel, ppu_r_nw, ppu_wdata, exp_b);
        end
        writes++;
      end
      prev_ncs = ppu_ncs;
    end
    cpu_req = 1'b0;
    checks++;
    if (ack_cycle != 2054 || cpu_rdata !== 8'h3C || bad_ack != 0) begin
      errors++;
      $display("[TB] FAIL dma_stalled_req got ack_cycle=%0d rdata=%h acks_during_dma=%0d want 2054/3c/0", ack_cycle, cpu_rdata, bad_ack);
    end
    checks++;
    if (busy_cycles != 2048 || strobes != 256 || writes != 256) begin
      errors++;
      $display("[TB] FAIL dma_counts got busy=%0d strobes=%0d writes=%0d want 2048/256/256", busy_cycles, strobes, writes);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int hit = 0;
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 16'h2005; cpu_wdata = 8'h77;
    tick();
    tick();
    rst = 1'b1; cpu_req = 1'b0;
    tick();
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL reset_mid_access got %h want %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({ppu_ncs, cpu_ack} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL reset_access_after c%0d ncs/ack got %b want 10", c, {ppu_ncs, cpu_ack});
      end
    end
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h03;
    tick();
    cpu_req = 1'b0;
    for (int c = 0; c < 1200 && hit == 0; c++) begin
      tick();
      if (mem_rd && mem_addr[7:0] == 8'd100) hit = 1;
    end
    checks++;
    if (hit == 0) begin
      errors++;
      $display("[TB] FAIL reset_dma_byte100 timeout got no strobe want strobe at 0364");
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("[TB] FAIL reset_mid_dma got %h want %h", out_vec(), RESET_VEC);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ({ppu_ncs, cpu_ack, dma_busy, mem_rd} !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL reset_dma_after c%0d ncs/ack/busy/rd got %b want 1000", c, {ppu_ncs, cpu_ack, dma_busy, mem_rd});
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_addr = 16'h0000;
    cpu_wdata = 8'h00; ppu_rdata = 8'h00;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignored();
    test_dma();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_cpu_bridge.md
Name: ppu_cpu_bridge

Overview:
CPU-side initiator for the PPU register interface. It turns single CPU bus requests into slow, edge-detectable register accesses: ppu_ncs is held low for a fixed window with sel, r_nw and data held stable, followed by a recovery gap. It also owns the $4014 sprite DMA engine, which copies a 256-byte CPU memory page into $2004. It sits between the CPU core / address decoder and the PPU register block.

Parameters:
NCS_LOW_CYCLES, 4, clk cycles ppu_ncs is held low per access; legal range 2..15.
NCS_HIGH_CYCLES, 2, minimum clk cycles ppu_ncs is held high after each access; legal range 1..15.

Ports:
clk  in  1  system clock (25 MHz)
rst  in  1  synchronous, active-high reset
cpu_req  in  1  request; held high with stable addr/data until cpu_ack
cpu_rnw  in  1  1 = read, 0 = write
cpu_addr  in  16  CPU address
cpu_wdata  in  8  write data
cpu_rdata  out  8  read data; valid while cpu_ack = 1
cpu_ack  out  1  one-cycle completion pulse
dma_busy  out  1  sprite DMA in progress (CPU stall)
mem_addr  out  16  DMA source address
mem_rd  out  1  one-cycle DMA read strobe
mem_rdata  in  8  DMA read data, valid the cycle after mem_rd
ppu_ncs  out  1  register select, active low
ppu_sel  out  3  register index (#2000-#2007)
ppu_r_nw  out  1  1 = read, 0 = write
ppu_wdata  out  8  data to PPU
ppu_rdata  in  8  data from PPU

Behaviour:
- Reset values: ppu_ncs=1, ppu_sel=0, ppu_r_nw=1, ppu_wdata=0, cpu_rdata=0, cpu_ack=0, dma_busy=0, mem_rd=0, mem_addr=0. Reset mid-access or mid-DMA abandons the operation immediately and returns to IDLE. No ack is issued.
- Address decode, applied only when a request is accepted in IDLE:
  - PPU access: 0x2000 <= addr <= 0x3FFF. ppu_sel = addr[2:0], which mirrors every 8 bytes.
  - DMA start: addr == 0x4014 with cpu_rnw = 0.
  - Any other address, and reads of 0x4014: ignored. No ack, no state change.
- States: IDLE, ACCESS, RECOVER, DMA_RD, DMA_WAIT.
- IDLE to ACCESS on an accepted PPU request (cycle 0):
  - Latch sel, r_nw and wdata.
  - ppu_ncs goes low from cycle 1 through cycle NCS_LOW_CYCLES inclusive.
  - The outputs stay stable across the whole low window.
- ACCESS to RECOVER after NCS_LOW_CYCLES cycles:
  - For a read, ppu_rdata is sampled on the last low cycle into cpu_rdata.
  - On the first high cycle (cycle NCS_LOW_CYCLES+1), cpu_ack=1 for one cycle and ppu_r_nw returns to 1.
  - For a CPU write, cpu_rdata holds its previous value.
- RECOVER: ppu_ncs=1 for NCS_HIGH_CYCLES cycles (counted from the ack cycle), then go to IDLE.
  - A request pending during RECOVER is accepted in the first IDLE cycle.
  - Back-to-back falling edges are therefore spaced at least NCS_LOW_CYCLES+NCS_HIGH_CYCLES+1 cycles apart.
- DMA start (cycle 0): latch page P = cpu_wdata, set dma_busy=1 from cycle 1, pulse cpu_ack at cycle 1, byte index i=0, then go to DMA_RD.
- DMA_RD: mem_addr={P,i}, mem_rd=1 for one cycle.
- DMA_WAIT: capture mem_rdata into ppu_wdata, set ppu_sel=4 and ppu_r_nw=0.
- The DMA write then uses the ACCESS/RECOVER sequence above, with no cpu_ack. After RECOVER, i increments (8-bit).
  - If i was 255, dma_busy drops and the block returns to IDLE.
  - Otherwise it returns to DMA_RD.
- DMA cost: 256 x (2 + NCS_LOW_CYCLES + NCS_HIGH_CYCLES) cycles, which is 2048 cycles at the defaults.
- While dma_busy=1, cpu_req is not accepted and gets no ack. It is served after DMA completes.
- mem_rd is never high outside DMA_RD. ppu_ncs is never low outside ACCESS.
- Counters are 4 bits and saturate-free; parameters outside the legal range are unsupported.

Test Plan:
- Write 0x2000=0x80:
  - ppu_ncs low on cycles 1-4, with sel=0, r_nw=0, wdata=0x80 stable.
  - cpu_ack=1 at cycle 5 only.
  - ppu_ncs high on cycles 5-6.
- Read 0x3FFA with ppu_rdata=0xA5: sel=2, r_nw=1, cpu_rdata=0xA5 while cpu_ack=1 at cycle 5.
- Two back-to-back writes (0x2006=0x21, then 0x2006=0x08): second ncs falling edge occurs exactly 7 cycles after the first, with no overlap.
- Write 0x4014=0x02 with memory byte k = k XOR 0x5A:
  - 256 ppu writes to sel=4 carry data 0x5A, 0x5B, ... in order.
  - mem_addr runs 0x0200-0x02FF.
  - dma_busy is high for 2048 cycles.
  - A cpu_req to 0x2002 issued during DMA is acked only after dma_busy falls.
- Requests to 0x4000, and a read of 0x4014: no ack, no ncs activity for 20 cycles.
- rst asserted on cycle 2 of an access and on byte 100 of a DMA: all outputs return to reset values the next cycle, and no ack is issued.
